// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared types and constants for the round-robin bus arbiter.
//   state_e               : arbiter FSM state (IDLE, OWNED)
//   id_width()            : width of an owner index for a given requester count
//   DefaultTimeoutCycles  : default hold limit, used with BUS_ARBITER_TIMEOUT_EN
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  localparam int DefaultTimeoutCycles = 256;

  // An index needs at least one bit, even for a single requester.
  function automatic int id_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selection. Searches upward from last_i+1,
// wrapping modulo Count, for the first set request bit.
// Ports:
//   req_i   [Count]   request vector (already masked by the caller)
//   last_i  [IdWidth] index of the previous winner
//   valid_o           a winner exists
//   grant_o [Count]   one-hot winner
//   id_o    [IdWidth] winner index (0 when no winner)
// -----------------------------------------------------------------------------
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter  int Count   = 4,
  localparam int IdWidth = id_width(Count)
) (
  input  logic [Count-1:0]   req_i,
  input  logic [IdWidth-1:0] last_i,
  output logic               valid_o,
  output logic [Count-1:0]   grant_o,
  output logic [IdWidth-1:0] id_o
);

  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    grant_o = '0;
    id_o    = '0;
    // i runs 1..Count so last_i itself is examined last.
    for (int i = 1; i <= Count; i++) begin
      idx = (int'(last_i) + i) % Count;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = IdWidth'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter granting exclusive ownership of a shared OR-reduced bus.
// At most one grant is active; one idle turnaround cycle separates owners.
// Optional hold-limit feature: define BUS_ARBITER_TIMEOUT_EN.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   req_i       [Count]   per-requester request, held for the transaction
//   grant_o     [Count]   one-hot grant, zero when idle
//   grant_id_o  [IdWidth] current owner index, 0 when idle
//   busy_o      any grant asserted
//   timeout_o   one-cycle pulse on forced release (0 without the feature)
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int Count         = 4,
  parameter  int TimeoutCycles = DefaultTimeoutCycles,
  localparam int IdWidth       = id_width(Count)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [Count-1:0]   req_i,
  output logic [Count-1:0]   grant_o,
  output logic [IdWidth-1:0] grant_id_o,
  output logic               busy_o,
  output logic               timeout_o
);

  state_e             state_q, state_d;
  logic [Count-1:0]   grant_q, grant_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic               busy_q, busy_d;
  logic [IdWidth-1:0] last_q, last_d;

  logic [Count-1:0]   pick_req;
  logic               pick_vld;
  logic [Count-1:0]   pick_grant;
  logic [IdWidth-1:0] pick_id;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles);
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Count-1:0] mask_q, mask_d;
  logic             timeout_q, timeout_d;

  // A timed-out requester stays out of arbitration until it lets go.
  assign pick_req  = req_i & ~mask_q;
  assign timeout_o = timeout_q;
`else
  assign pick_req  = req_i;
  assign timeout_o = 1'b0;
`endif

  rr_picker #(.Count(Count)) u_picker (
    .req_i   (pick_req),
    .last_i  (last_q),
    .valid_o (pick_vld),
    .grant_o (pick_grant),
    .id_o    (pick_id)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    busy_d  = busy_q;
    last_d  = last_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
    mask_d    = mask_q & req_i;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_grant;
          id_d    = pick_id;
          busy_d  = 1'b1;
          last_d  = pick_id;
          state_d = OWNED;
`ifdef BUS_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      OWNED: begin
        // No arbitration on the release edge: that yields the turnaround cycle.
        if (!req_i[id_q]) begin
          grant_d = '0;
          id_d    = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          grant_d      = '0;
          id_d         = '0;
          busy_d       = 1'b0;
          state_d      = IDLE;
          timeout_d    = 1'b1;
          mask_d[id_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      last_q  <= IdWidth'(Count - 1);
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q     <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = id_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter: a Count=4 instance (TimeoutCycles=8 when
// BUS_ARBITER_TIMEOUT_EN is defined) and a Count=1 instance sharing clk/rst.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] gid;
  logic       busy;
  logic       tmo;

  logic       req1;
  logic       grant1;
  logic       gid1;
  logic       busy1;
  logic       tmo1;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .Count         (4),
`ifdef BUS_ARBITER_TIMEOUT_EN
    .TimeoutCycles (8)
`else
    .TimeoutCycles (256)
`endif
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .grant_o    (grant),
    .grant_id_o (gid),
    .busy_o     (busy),
    .timeout_o  (tmo)
  );

  bus_arbiter #(.Count(1)) dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req1),
    .grant_o    (grant1),
    .grant_id_o (gid1),
    .busy_o     (busy1),
    .timeout_o  (tmo1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                          input logic eb, input logic et);
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".id"},    32'(gid),   32'(eid));
    chk({tag, ".busy"},  32'(busy),  32'(eb));
    chk({tag, ".tmo"},   32'(tmo),   32'(et));
  endtask

  initial begin
    logic [3:0] oh;
    rst  = 1'b1;
    req  = 4'b0000;
    req1 = 1'b0;
    tick();
    chk_main("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("reset1.grant", 32'(grant1), 32'd0);
    chk("reset1.busy",  32'(busy1),  32'd0);
    rst = 1'b0;

    // Single request, one-cycle latency.
    req = 4'b0100;
    tick();
    chk_main("single", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk_main("single_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Rotation with all requesting; each owner holds 3 cycles then drops once.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      tick();
      chk_main($sformatf("rot%0d_c1", k), oh, 2'(k % 4), 1'b1, 1'b0);
      tick();
      chk($sformatf("rot%0d_c2", k), 32'(grant), 32'(oh));
      tick();
      chk($sformatf("rot%0d_c3", k), 32'(grant), 32'(oh));
      req = 4'b1111 & ~oh;
      tick();
      chk_main($sformatf("rot%0d_gap", k), 4'b0000, 2'd0, 1'b0, 1'b0);
      req = 4'b1111;
    end
    req = 4'b0000;
    tick();
    chk("rot_end", 32'(grant), 32'd0);

    // Non-owner requests are ignored while owned (pointer is at 0 here).
    req = 4'b0010;
    tick();
    chk_main("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1010;
    tick();
    chk("own1_hold_a", 32'(grant), 32'h2);
    tick();
    chk("own1_hold_b", 32'(grant), 32'h2);
    req = 4'b1000;
    tick();
    chk_main("own1_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_main("own3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk("own3_rel", 32'(grant), 32'd0);

    // Dropping a request before it is granted loses the turn.
    req = 4'b0000;
    tick();
    chk("drop_idle", 32'(grant), 32'd0);

    // Reset during ownership of requester 2.
    req = 4'b0100;
    tick();
    chk_main("rst_own2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0101;
    rst = 1'b1;
    tick();
    chk_main("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_main("rst_after", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk("rst_after_rel", 32'(grant), 32'd0);

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Forced release after 8 owned cycles; 0 masked until its request drops.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    tick();
    chk_main("to_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk($sformatf("to_hold%0d", c), 32'({tmo, grant}), 32'h01);
    end
    tick();
    chk_main("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_main("to_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0001;
    tick();
    chk_main("to_rel1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk("to_masked", 32'(grant), 32'd0);
    req = 4'b0000;
    tick();
    chk("to_drop0", 32'(grant), 32'd0);
    req = 4'b0001;
    tick();
    chk_main("to_regrant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
`else
    // Without the hold limit ownership is unbounded.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    tick();
    chk_main("long_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) tick();
    chk_main("long_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk("long_rel", 32'(grant), 32'd0);
`endif

    // Count=1: requests 1,1,0,1.
    req1 = 1'b1;
    tick();
    chk("c1_a", 32'({busy1, grant1}), 32'h3);
    tick();
    chk("c1_b", 32'({busy1, grant1}), 32'h3);
    req1 = 1'b0;
    tick();
    chk("c1_rel", 32'({busy1, grant1}), 32'h0);
    req1 = 1'b1;
    tick();
    chk("c1_again", 32'({busy1, grant1}), 32'h3);
    chk("c1_id", 32'(gid1), 32'd0);
    chk("c1_tmo", 32'(tmo1), 32'd0);
    req1 = 1'b0;
    tick();
    chk("c1_end", 32'(grant1), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that grants exclusive ownership of a shared OR-reduced bus to one of Count requesters.
- Guarantees at most one requester holds a grant at any time, so the OR-reduction of all requester words equals the owner's word.
- Inserts one idle turnaround cycle between owners.
- Sits in front of the bus word reducer; its grant vector gates each requester's word driver.

Parameters:
- Count, 4, number of requesters (>=1).
- TimeoutCycles, 256, maximum cycles one owner may hold the grant (used only with the optional feature; >=2).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous active-high reset.
- req_i  input  Count  per-requester request; held high for the whole transaction.
- grant_o  output  Count  one-hot grant (all zero when idle).
- grant_id_o  output  IdWidth  index of current owner; 0 when idle. IdWidth = max(1, $clog2(Count)).
- busy_o  output  1  high while any grant is asserted.
- timeout_o  output  1  one-cycle pulse on forced release (optional feature only; tied 0 otherwise).

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - grant_o=0, grant_id_o=0, busy_o=0, timeout_o=0.
  - State IDLE.
  - Round-robin pointer last_q=Count-1, so requester 0 has first priority after reset.
- All outputs are registered.
- State IDLE:
  - If any req_i bit is set, pick the first set bit searching upward from last_q+1, wrapping modulo Count.
  - On that edge: grant_o, grant_id_o and busy_o are loaded, last_q takes the winner's index, state goes to OWNED.
  - Grant latency: 1 cycle after req_i is sampled.
- State OWNED:
  - grant_o holds while req_i[grant_id_o] is high.
  - When req_i[grant_id_o] is low at an edge, outputs clear (grant_o=0, busy_o=0, grant_id_o=0) and state returns to IDLE.
  - No arbitration occurs on the release edge. This guarantees at least one zero-grant turnaround cycle between owners.
  - req_i changes from non-owners are ignored in OWNED.
- Fairness: with all requesters constantly requesting, grants rotate 0,1,...,Count-1,0,...
- A requester that drops req_i before it is granted loses its turn; no request latching.
- Count=1: the pointer always selects 0 and turnaround still applies.
- Reset asserted mid-ownership clears the grant on that edge; the pointer returns to Count-1.
- Requests asserted during the reset cycle are not granted until the first IDLE cycle after reset.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- Enabled:
  - Hold counter cleared on grant and incremented every OWNED cycle.
  - When the counter reaches TimeoutCycles-1 while the owner still requests, the grant is forcibly cleared (returns to IDLE).
  - timeout_o pulses high for one cycle, coincident with the grant clearing.
  - The offending index is masked from arbitration until its req_i is seen low.
  - Normal release before the limit behaves exactly as without the feature.
- Disabled: no counter or mask logic is present; timeout_o is constant 0; ownership is unbounded.

Decomposition:
- Package bus_arbiter_pkg:
  - state enum (IDLE, OWNED);
  - function computing IdWidth from Count;
  - default TimeoutCycles constant.
- Sub-module rr_picker: purely combinational. Inputs are a Count-bit request vector (already masked) and the last index. Outputs are a valid flag, a one-hot winner and the winner index. bus_arbiter instantiates it once.

Test Plan:
- Reset then req_i=4'b0100 -> grant_o=4'b0100 and grant_id_o=2 one cycle later; busy_o=1.
- req_i=4'b1111 held continuously -> grant sequence 0,1,2,3,0. Each owner releases after 3 cycles; exactly one all-zero grant cycle between consecutive owners.
- Owner 1 granted, then req_i[3] rises while req_i[1] stays high -> grant_o stays 4'b0010. Drop req_i[1] -> idle cycle, then grant_o=4'b1000.
- Reset asserted during ownership of requester 2 -> next cycle grant_o=0 and busy_o=0. With req_i=4'b0101 held, requester 0 is granted first after reset.
- With BUS_ARBITER_TIMEOUT_EN and TimeoutCycles=8: requester 0 holds req for 20 cycles while requester 1 also requests -> timeout_o pulses after 8 owned cycles, grant_o goes to 0, then requester 1 is granted. Requester 0 is not re-granted until its req drops and rises again.
- Count=1 configuration: req_i toggles 1,1,0,1 -> grant follows with 1-cycle latency and a turnaround cycle after each release.
